// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 Set-2 scan-code decoder: prefix bytes,
// bytes the keyboard sends that carry no key meaning, modifier key codes
// and the 2-bit FSM state encoding.
package ps2_pkg;

    localparam logic [7:0] CODE_E0     = 8'hE0;
    localparam logic [7:0] CODE_F0     = 8'hF0;

    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_BAT    = 8'hAA;
    localparam logic [7:0] CODE_ECHO   = 8'hEE;
    localparam logic [7:0] CODE_RESEND = 8'hFE;
    localparam logic [7:0] CODE_PAUSE  = 8'hE1;

    localparam logic [7:0] CODE_OVR0   = 8'h00;
    localparam logic [7:0] CODE_OVRF   = 8'hFF;

    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CTRL   = 8'h14;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GOT_E0   = 2'd1;
    localparam logic [1:0] ST_GOT_F0   = 2'd2;
    localparam logic [1:0] ST_GOT_E0F0 = 2'd3;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == CODE_E0) || (b == CODE_F0);
    endfunction

    // Controller responses and the Pause lead-in; dropped silently in IDLE.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == CODE_ACK) || (b == CODE_BAT) || (b == CODE_ECHO) ||
               (b == CODE_RESEND) || (b == CODE_PAUSE);
    endfunction

    // Keyboard buffer overrun markers.
    function automatic logic is_overrun(input logic [7:0] b);
        return (b == CODE_OVR0) || (b == CODE_OVRF);
    endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational Set-2 to ASCII translation for letters, digits, space,
// enter and backspace. Shift/caps are the modifier state seen before the
// key being translated.
module ps2_ascii_lut
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii,
    output logic       mapped
);

    logic [7:0] letter;
    logic       is_letter;
    logic [3:0] digit;
    logic       is_digit;
    logic [7:0] digit_shifted;

    // Letter table: lowercase ASCII for each Set-2 letter code.
    always_comb begin
        letter    = 8'h00;
        is_letter = 1'b1;
        case (code)
            8'h1C: letter = 8'h61; // a
            8'h32: letter = 8'h62; // b
            8'h21: letter = 8'h63; // c
            8'h23: letter = 8'h64; // d
            8'h24: letter = 8'h65; // e
            8'h2B: letter = 8'h66; // f
            8'h34: letter = 8'h67; // g
            8'h33: letter = 8'h68; // h
            8'h43: letter = 8'h69; // i
            8'h3B: letter = 8'h6A; // j
            8'h42: letter = 8'h6B; // k
            8'h4B: letter = 8'h6C; // l
            8'h3A: letter = 8'h6D; // m
            8'h31: letter = 8'h6E; // n
            8'h44: letter = 8'h6F; // o
            8'h4D: letter = 8'h70; // p
            8'h15: letter = 8'h71; // q
            8'h2D: letter = 8'h72; // r
            8'h1B: letter = 8'h73; // s
            8'h2C: letter = 8'h74; // t
            8'h3C: letter = 8'h75; // u
            8'h2A: letter = 8'h76; // v
            8'h1D: letter = 8'h77; // w
            8'h22: letter = 8'h78; // x
            8'h35: letter = 8'h79; // y
            8'h1A: letter = 8'h7A; // z
            default: is_letter = 1'b0;
        endcase
    end

    // Digit row: numeric value of each top-row digit key.
    always_comb begin
        digit    = 4'd0;
        is_digit = 1'b1;
        case (code)
            8'h45: digit = 4'd0;
            8'h16: digit = 4'd1;
            8'h1E: digit = 4'd2;
            8'h26: digit = 4'd3;
            8'h25: digit = 4'd4;
            8'h2E: digit = 4'd5;
            8'h36: digit = 4'd6;
            8'h3D: digit = 4'd7;
            8'h3E: digit = 4'd8;
            8'h46: digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    // US-layout shifted symbols on the digit row.
    always_comb begin
        case (digit)
            4'd0:    digit_shifted = 8'h29; // )
            4'd1:    digit_shifted = 8'h21; // !
            4'd2:    digit_shifted = 8'h40; // @
            4'd3:    digit_shifted = 8'h23; // #
            4'd4:    digit_shifted = 8'h24; // $
            4'd5:    digit_shifted = 8'h25; // %
            4'd6:    digit_shifted = 8'h5E; // ^
            4'd7:    digit_shifted = 8'h26; // &
            4'd8:    digit_shifted = 8'h2A; // *
            4'd9:    digit_shifted = 8'h28; // (
            default: digit_shifted = 8'h00;
        endcase
    end

    // Final select; caps lock affects letters only.
    always_comb begin
        ascii  = 8'h00;
        mapped = 1'b1;
        if (is_letter) begin
            ascii = (shift ^ caps) ? (letter - 8'h20) : letter;
        end else if (is_digit) begin
            ascii = shift ? digit_shifted : (8'h30 + {4'h0, digit});
        end else begin
            case (code)
                8'h29:   ascii = 8'h20;
                8'h5A:   ascii = 8'h0D;
                8'h66:   ascii = 8'h08;
                default: mapped = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns the PS/2 Set-2 byte stream into key events with E0/F0 prefix
// handling, modifier tracking and ASCII translation.
//
// state       | meaning
// ------------+---------------------------------------------------
// ST_IDLE     | no prefix pending; next byte starts a sequence
// ST_GOT_E0   | E0 seen; expecting F0 or the extended key code
// ST_GOT_F0   | F0 seen; expecting the released key code
// ST_GOT_E0F0 | E0 F0 seen; expecting the released extended code
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_sent,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_break,
    output logic [7:0] key_ascii,
    output logic       ascii_valid,
    output logic       shift_state,
    output logic       ctrl_state,
    output logic       caps_lock,
    output logic       err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             sent_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_valid_q, key_valid_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_extended_q, key_extended_d;
    logic             key_break_q, key_break_d;
    logic [7:0]       key_ascii_q, key_ascii_d;
    logic             ascii_valid_q, ascii_valid_d;
    logic             lshift_q, lshift_d;
    logic             rshift_q, rshift_d;
    logic             ctrl_q, ctrl_d;
    logic             caps_q, caps_d;
    logic             caps_held_q, caps_held_d;
    logic             err_q, err_d;

    logic       new_byte;
    logic       emit;
    logic       ev_ext;
    logic       ev_brk;
    logic [7:0] lut_ascii;
    logic       lut_mapped;

    assign new_byte = scan_sent & ~sent_q;

    ps2_ascii_lut u_ascii_lut (
        .code   (scan_code),
        .shift  (lshift_q | rshift_q),
        .caps   (caps_q),
        .ascii  (lut_ascii),
        .mapped (lut_mapped)
    );

    // Prefix FSM and inactivity timeout; decides whether this byte is an event.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        err_d   = 1'b0;
        if (new_byte) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == CODE_E0)       state_d = ST_GOT_E0;
                    else if (scan_code == CODE_F0)  state_d = ST_GOT_F0;
                    else if (is_overrun(scan_code)) err_d   = 1'b1;
                    else if (!is_ignored(scan_code)) emit   = 1'b1;
                end
                ST_GOT_E0: begin
                    if (scan_code == CODE_F0) begin
                        state_d = ST_GOT_E0F0;
                    end else if (scan_code == CODE_E0) begin
                        err_d = 1'b1;
                    end else begin
                        emit    = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_GOT_F0: begin
                    state_d = ST_IDLE;
                    if (is_prefix(scan_code)) begin
                        err_d = 1'b1;
                    end else begin
                        emit   = 1'b1;
                        ev_brk = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    if (is_prefix(scan_code)) begin
                        err_d = 1'b1;
                    end else begin
                        emit   = 1'b1;
                        ev_ext = 1'b1;
                        ev_brk = 1'b1;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_MAX) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (state_d == ST_IDLE) cnt_d = '0;
    end

    // Event outputs and modifier tracking, updated on the event edge.
    always_comb begin
        key_valid_d    = emit;
        key_code_d     = key_code_q;
        key_extended_d = key_extended_q;
        key_break_d    = key_break_q;
        key_ascii_d    = key_ascii_q;
        ascii_valid_d  = 1'b0;
        lshift_d       = lshift_q;
        rshift_d       = rshift_q;
        ctrl_d         = ctrl_q;
        caps_d         = caps_q;
        caps_held_d    = caps_held_q;
        if (emit) begin
            key_code_d     = scan_code;
            key_extended_d = ev_ext;
            key_break_d    = ev_brk;
            ascii_valid_d  = lut_mapped & ~ev_ext & ~ev_brk;
            key_ascii_d    = (lut_mapped && !ev_ext && !ev_brk) ? lut_ascii : 8'h00;
            if (!ev_ext) begin
                case (scan_code)
                    CODE_LSHIFT: lshift_d = ~ev_brk;
                    CODE_RSHIFT: rshift_d = ~ev_brk;
                    CODE_CTRL:   ctrl_d   = ~ev_brk;
                    CODE_CAPS: begin
                        // Typematic repeats arrive as makes with no break;
                        // only the first make after a release toggles.
                        if (ev_brk) begin
                            caps_held_d = 1'b0;
                        end else begin
                            if (!caps_held_q) caps_d = ~caps_q;
                            caps_held_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registers; sent_q tracks scan_sent even in reset so a level already
    // high at release is not mistaken for a new byte.
    always_ff @(posedge clk) begin
        sent_q <= scan_sent;
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            key_valid_q    <= 1'b0;
            key_code_q     <= 8'h00;
            key_extended_q <= 1'b0;
            key_break_q    <= 1'b0;
            key_ascii_q    <= 8'h00;
            ascii_valid_q  <= 1'b0;
            lshift_q       <= 1'b0;
            rshift_q       <= 1'b0;
            ctrl_q         <= 1'b0;
            caps_q         <= 1'b0;
            caps_held_q    <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            key_valid_q    <= key_valid_d;
            key_code_q     <= key_code_d;
            key_extended_q <= key_extended_d;
            key_break_q    <= key_break_d;
            key_ascii_q    <= key_ascii_d;
            ascii_valid_q  <= ascii_valid_d;
            lshift_q       <= lshift_d;
            rshift_q       <= rshift_d;
            ctrl_q         <= ctrl_d;
            caps_q         <= caps_d;
            caps_held_q    <= caps_held_d;
            err_q          <= err_d;
        end
    end

    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_extended = key_extended_q;
    assign key_break    = key_break_q;
    assign key_ascii    = key_ascii_q;
    assign ascii_valid  = ascii_valid_q;
    assign shift_state  = lshift_q | rshift_q;
    assign ctrl_state   = ctrl_q;
    assign caps_lock    = caps_q;
    assign err          = err_q;

endmodule
